pu_feeder: RTL

//  Upstream loader for one img2col processing unit (PU1). Accepts a pixel stream
//  (valid/ready) from the AXI read path and writes it into the PU's 25-entry new-data

---
 rtl/pu_feeder_if.sv | 16 +
 rtl/pu_feeder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pu_feeder_if.sv
// rtl/pu_feeder_if.sv - pixel stream handshake bundle feeding pu_feeder
// Purpose : valid/ready pixel stream from the AXI read path into the feeder.
// Signals : s_valid  word valid (source -> feeder)
//           s_data   pixel word (source -> feeder)
//           s_ready  feeder accepts word this cycle (feeder -> source)
// Modports: master = stream source, slave = feeder side.
interface pu_feeder_if #(
  parameter int data_width = 16
) ();
  logic                  s_valid;
  logic [data_width-1:0] s_data;
  logic                  s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/pu_feeder.sv
// rtl/pu_feeder.sv - round sequencer loading pixel words into the PU1 register file
// Purpose : accepts pixel words and writes them into the PU's 25-entry new-data
//           register file. Round 0 loads a full window, later rounds load one
//           new kernel column. Pulses start per round and done after the last.
// Ports   : clk, nrst (sync active-low), go, num_rounds[5:0]
//           s_in (pu_feeder_if.slave: s_valid, s_data, s_ready)
//           new1, adrs_in1, adrs_in2, wr_ctrl_g   register-file write port
//           start, round[5:0]                      per-round handshake to PU
//           busy, done                             job status
//           stall_cnt[15:0]                        only with PU_FEEDER_STALL_CNT_EN
// Config  : PU_FEEDER_STALL_CNT_EN adds a saturating count of LOAD cycles with
//           s_valid low, cleared by reset and on an accepted go.
module pu_feeder #(
  parameter int data_width  = 16,
  parameter int weight_size = 25,
  parameter int address_num = 5,
  parameter int reg_num     = 20,
  parameter int kw          = 5,
  parameter int pu_lat      = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   go,
  input  logic [5:0]             num_rounds,
  pu_feeder_if.slave             s_in,
  output logic [data_width-1:0]  new1,
  output logic [address_num-1:0] adrs_in1,
  output logic [address_num-1:0] adrs_in2,
  output logic                   wr_ctrl_g,
  output logic                   start,
  output logic [5:0]             round,
  output logic                   busy,
  output logic                   done
`ifdef PU_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, FIRE, WAIT} state_t;

  localparam logic [address_num-1:0] LAST_FULL = address_num'(weight_size - 1);
  localparam logic [address_num-1:0] LAST_COL  = address_num'(weight_size - reg_num - 1);
  localparam logic [address_num-1:0] K_LAST    = address_num'(kw - 1);
  localparam logic [address_num-1:0] KW_A      = address_num'(kw);
  localparam logic [7:0]             WAIT_LAST = 8'(pu_lat);

  state_t                 state_q, state_d;
  logic [5:0]             round_q, round_d;
  logic [5:0]             nr_q, nr_d;
  logic [address_num-1:0] idx_q, idx_d;    // words accepted in this round
  logic [address_num-1:0] k_q, k_d;        // word position inside the current column
  logic [address_num-1:0] base_q, base_d;  // first address of the current column
  logic [address_num-1:0] col_q, col_d;    // column replaced by rounds > 0
  logic [7:0]             wcnt_q, wcnt_d;
  logic                   wr_q, wr_d;
  logic [data_width-1:0]  new1_q, new1_d;
  logic [address_num-1:0] a1_q, a1_d;
  logic [address_num-1:0] a2_q, a2_d;
  logic                   start_q, start_d;
  logic                   done_q, done_d;
  logic [address_num-1:0] col_nxt;
  logic                   beat;

  assign s_in.s_ready = (state_q == LOAD);
  assign beat         = s_in.s_valid && (state_q == LOAD);

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    nr_d    = nr_q;
    idx_d   = idx_q;
    k_d     = k_q;
    base_d  = base_q;
    col_d   = col_q;
    wcnt_d  = wcnt_q;
    wr_d    = 1'b0;
    new1_d  = new1_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    col_nxt = '0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = LOAD;
          nr_d    = (num_rounds == 6'd0) ? 6'd1 : num_rounds;
          round_d = '0;
          idx_d   = '0;
          k_d     = '0;
          base_d  = '0;
          col_d   = '0;
        end
      end
      LOAD: begin
        if (beat) begin
          wr_d   = 1'b1;
          new1_d = s_in.s_data;
          a1_d   = base_q + k_q;
          a2_d   = base_q;
          idx_d  = idx_q + 1'b1;
          // Round 0 walks every column; later rounds stay on one column.
          if (k_q == K_LAST) begin
            k_d = '0;
            if (round_q == 6'd0) begin
              base_d = base_q + KW_A;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
          if (idx_q == ((round_q == 6'd0) ? LAST_FULL : LAST_COL)) begin
            state_d = FIRE;
            idx_d   = '0;
          end
        end
      end
      FIRE: begin
        // Registered, so start lands one cycle after the last write strobe.
        start_d = 1'b1;
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // The start cycle is wcnt 0; pu_lat further cycles follow it.
        if (wcnt_q == WAIT_LAST) begin
          if (round_q < (nr_q - 6'd1)) begin
            col_nxt = (round_q == 6'd0) ? '0 :
                      ((col_q == K_LAST) ? '0 : col_q + 1'b1);
            col_d   = col_nxt;
            base_d  = address_num'(col_nxt * kw);
            k_d     = '0;
            round_d = round_q + 6'd1;
            state_d = LOAD;
          end else begin
            round_d = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      round_q <= '0;
      nr_q    <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      base_q  <= '0;
      col_q   <= '0;
      wcnt_q  <= '0;
      wr_q    <= 1'b0;
      new1_q  <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      nr_q    <= nr_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      base_q  <= base_d;
      col_q   <= col_d;
      wcnt_q  <= wcnt_d;
      wr_q    <= wr_d;
      new1_q  <= new1_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

`ifdef PU_FEEDER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && go) begin
      stall_d = '0;
    end else if (state_q == LOAD && !s_in.s_valid && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign new1      = new1_q;
  assign adrs_in1  = a1_q;
  assign adrs_in2  = a2_q;
  assign wr_ctrl_g = wr_q;
  assign start     = start_q;
  assign round     = round_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule
